ads131_frame_receiver: RTL and testbench
========================================

# ads131_frame_receiver

Passive SPI receive stage for the ADS131A0X ADC, sitting directly downstream of the SPI master. It oversamples the master's `SPI_SCLK`, `SPI_CS` and the ADC's `SPI_MISO` on `system_clock`, deserialises each CS-framed transfer into 24-bit words, and presents:
- the status/response word, which the master's command sequencer compares against READY 0xFF04 and ACK 0x0655;
- the per-channel conversion samples, as a registered, validated frame.

## Interface
Parameters:
- `WORD_BITS`, 24: bits per ADC word (M0 word-length setting); legal values 16, 24, 32.
- `NUM_CH`, 4: ADC channels per frame. A frame is 1 status word + `NUM_CH` data words (+1 CRC word when `ADS131_CRC_EN`).

Ports:
- `system_clock`  in  1  50 MHz system clock; must be ≥ 8× SCLK frequency.
- `reset`  in  1  asynchronous, active-high reset.
- `spi_sclk`  in  1  SCLK as driven by the master, asynchronous.
- `spi_cs`  in  1  CS as driven by the master, active-low, asynchronous.
- `spi_miso`  in  1  ADC data out, asynchronous.
- `status_word`  out  16  upper 16 bits of word 0 of the last transfer.
- `status_valid`  out  1  one-cycle pulse when `status_word` updates.
- `ch_data`  out  `NUM_CH*WORD_BITS`  channel samples, two's complement; ch0 in the LSBs.
- `data_valid`  out  1  one-cycle pulse when `ch_data` updates.
- `frame_err`  out  1  one-cycle pulse on a malformed transfer.
- `crc_err`  out  1  one-cycle pulse on a CRC mismatch; tied 0 without `ADS131_CRC_EN`.
- `bit_count`  out  8  debug: number of bits captured in the current or last transfer.

## Operation
- **Input synchronisation:** all three SPI inputs pass through 2-flop synchronisers, then a third register for edge detection.
- **State machine:**
  - IDLE: wait for CS falling edge → clear shift register, word index and bit counter → SHIFT.
  - SHIFT: on each synchronised SCLK falling edge, sample MISO, shifting MSB-first into a `WORD_BITS` shift register and incrementing `bit_count` (saturates at 255).
    - When the word bit count reaches `WORD_BITS`, store the word:
      - word 0 goes to the status holding register;
      - words 1..`NUM_CH` go to the channel staging registers;
      - words beyond the frame length are discarded.
    - Increment the word index.
    - CS rising edge → CLOSE.
  - CLOSE (1 cycle): evaluate the transfer, then → IDLE.
- **Evaluation in CLOSE:**
  - `bit_count` == 0: no outputs.
  - 0 < `bit_count` < `WORD_BITS`: `frame_err` pulse, nothing updated.
  - `bit_count` ≥ `WORD_BITS` and an exact multiple of `WORD_BITS`: `status_word` updated, `status_valid` pulse. Command-response transfers carry only word 0.
  - `bit_count` ≥ `WORD_BITS` but not a multiple of `WORD_BITS`: `frame_err` pulse; `status_word` is still updated from the complete word 0.
  - `bit_count` == full frame length exactly: additionally copy the staging registers to `ch_data` and pulse `data_valid`.
  - Longer than a full frame: `frame_err`; `status_word` is updated, `ch_data` is not.
- **Reset:** all outputs reset to 0 and the FSM returns to IDLE.
  - Reset asserted mid-transfer abandons the frame.
  - After release, the FSM waits for the next CS falling edge; a CS already low at release is ignored until it goes high and low again.
- **Simultaneous events:** CS rising edge and SCLK falling edge in the same cycle: the sample is taken first, then CLOSE.

## Timing
- Pin-to-edge-detect latency: 3 `system_clock` cycles.
- `status_valid`, `data_valid`, `frame_err` and `crc_err` fire in the CLOSE cycle, 4 cycles after the CS rising edge at the pin.
- All pulses are exactly 1 cycle wide and mutually simultaneous where applicable.
- `ch_data` and `status_word` hold their values until the next qualifying transfer.
- Minimum CS-high time between transfers: 2 SCLK periods. Shorter gaps are not guaranteed to be detected.

## Configuration
- `ADS131_CRC_EN` defined:
  - the frame grows by one word, the CRC word (last position);
  - a serial CRC-16-CCITT (polynomial 0x1021, init 0xFFFF) runs over every bit preceding the CRC word;
  - the CRC word's upper 16 bits are compared with the computed CRC in CLOSE;
  - on mismatch: `crc_err` pulse, no `data_valid`; `status_word` is still updated.
- `ADS131_CRC_EN` undefined: there is no CRC word and no CRC logic, and `crc_err` is constant 0.

## Structure
- Shared package `ads131_pkg`:
  - constants READY 0xFF04, ACK/UNLOCK 0x0655, LOCK 0x0555, CRC polynomial and init value;
  - the FSM state enum (IDLE, SHIFT, CLOSE).
- Sub-module `crc16_ccitt_serial`:
  - ports: clear, bit-enable, data bit, 16-bit CRC out;
  - compiled only under `ADS131_CRC_EN`.

## Test plan
- 24-bit transfer of 0xFF0400 → `status_word`=0xFF04, `status_valid` pulse, no `data_valid`, no `frame_err`.
- Full 5-word frame with status 0x2200 and ch0..ch3 = 0x000001, 0x7FFFFF, 0x800000, 0xFFFFFF → `data_valid`, with `ch_data` matching (ch3 in the MSBs).
- CS raised after 13 bits → `frame_err` pulse, `status_word` unchanged, `bit_count`=13.
- Reset asserted after 30 bits, released with CS still low, then a valid 0x065500 transfer → only the second transfer is reported (`status_word`=0x0655).
- Back-to-back 24-bit transfers 0x065500 then 0x055500 with a 2-SCLK CS gap → two `status_valid` pulses, values 0x0655 then 0x0555.
- With `ADS131_CRC_EN`: a correct frame → `data_valid`; the same frame with one data bit flipped → `crc_err` and no `data_valid`.

Source files
------------

// File: rtl/ads131_pkg.sv
// rtl/ads131_pkg.sv - shared constants, FSM state type and helpers for the ADS131A0x receive path
package ads131_pkg;

  localparam logic [15:0] ADS131_READY  = 16'hFF04;
  localparam logic [15:0] ADS131_ACK    = 16'h0655;
  localparam logic [15:0] ADS131_UNLOCK = 16'h0655;
  localparam logic [15:0] ADS131_LOCK   = 16'h0555;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CLOSE
  } rx_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ads131_frame_receiver_if.sv
// rtl/ads131_frame_receiver_if.sv - SPI pins plus decoded status/sample outputs of the frame receiver
interface ads131_frame_receiver_if #(
  parameter int WORD_BITS = 24,
  parameter int NUM_CH    = 4
);
  logic                        spi_sclk;
  logic                        spi_cs;
  logic                        spi_miso;
  logic [15:0]                 status_word;
  logic                        status_valid;
  logic [NUM_CH*WORD_BITS-1:0] ch_data;
  logic                        data_valid;
  logic                        frame_err;
  logic                        crc_err;
  logic [7:0]                  bit_count;

  modport master (
    output spi_sclk, spi_cs, spi_miso,
    input  status_word, status_valid, ch_data, data_valid, frame_err, crc_err, bit_count
  );

  modport slave (
    input  spi_sclk, spi_cs, spi_miso,
    output status_word, status_valid, ch_data, data_valid, frame_err, crc_err, bit_count
  );
endinterface

// File: rtl/crc16_ccitt_serial.sv
// rtl/crc16_ccitt_serial.sv - bit-serial CRC-16-CCITT, built only when ADS131_CRC_EN is defined
`ifdef ADS131_CRC_EN
module crc16_ccitt_serial
  import ads131_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        bit_en,
  input  logic        data_bit,
  output logic [15:0] crc
);
  logic feedback;

  assign feedback = crc[15] ^ data_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC_INIT;
    end else if (clear) begin
      crc <= CRC_INIT;
    end else if (bit_en) begin
      crc <= {crc[14:0], 1'b0} ^ (feedback ? CRC_POLY : 16'h0000);
    end
  end
endmodule
`else
`endif

// File: rtl/ads131_frame_receiver.sv
// rtl/ads131_frame_receiver.sv - oversampling SPI deserialiser for ADS131A0x frames
// Optional CRC word check is compiled in with ADS131_CRC_EN.
module ads131_frame_receiver
  import ads131_pkg::*;
#(
  parameter int WORD_BITS = 24,
  parameter int NUM_CH    = 4
) (
  input  logic                   system_clock,
  input  logic                   reset,
  ads131_frame_receiver_if.slave bus
);
`ifdef ADS131_CRC_EN
  localparam int CRC_WORDS = 1;
`else
  localparam int CRC_WORDS = 0;
`endif
  localparam int FRAME_WORDS = 1 + NUM_CH + CRC_WORDS;
  localparam int WB_W        = $clog2(WORD_BITS);
  localparam int CH_W        = NUM_CH * WORD_BITS;

  logic [2:0]           sclk_q, cs_q;
  logic [1:0]           miso_q;
  logic                 sclk_fall, cs_fall, cs_rise, miso_bit;
  rx_state_e            state, state_nxt;
  logic                 start, sample, word_done, close, partial, full_frame, crc_ok;
  logic                 sv_nxt, dv_nxt, fe_nxt;
  logic [WORD_BITS-2:0] shreg;
  logic [WORD_BITS-1:0] word_full;
  logic [WB_W-1:0]      word_bit;
  logic [7:0]           word_idx, bit_cnt;
  logic [15:0]          status_hold, status_word_q;
  logic [CH_W-1:0]      ch_stage, ch_data_q;
  logic                 sv_q, dv_q, fe_q;

  // Sync flops reset low so a CS already low at reset release never looks like a falling edge.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      sclk_q <= '0;
      cs_q   <= '0;
      miso_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], bus.spi_sclk};
      cs_q   <= {cs_q[1:0], bus.spi_cs};
      miso_q <= {miso_q[0], bus.spi_miso};
    end
  end

  assign sclk_fall = sclk_q[2] & ~sclk_q[1];
  assign cs_fall   = cs_q[2] & ~cs_q[1];
  assign cs_rise   = ~cs_q[2] & cs_q[1];
  assign miso_bit  = miso_q[1];

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    sample    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          start     = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sample = sclk_fall;
        if (cs_rise) state_nxt = ST_CLOSE;
      end
      ST_CLOSE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign word_full = {shreg, miso_bit};
  assign word_done = sample && (word_bit == WB_W'(WORD_BITS - 1));

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      word_bit    <= '0;
      word_idx    <= '0;
      bit_cnt     <= '0;
      status_hold <= '0;
      ch_stage    <= '0;
    end else if (start) begin
      shreg    <= '0;
      word_bit <= '0;
      word_idx <= '0;
      bit_cnt  <= '0;
    end else if (sample) begin
      shreg   <= word_full[WORD_BITS-2:0];
      bit_cnt <= sat_inc8(bit_cnt);
      if (word_done) begin
        word_bit <= '0;
        word_idx <= sat_inc8(word_idx);
        if (word_idx == 8'd0) begin
          status_hold <= word_full[WORD_BITS-1 -: 16];
        end else if (word_idx <= 8'(NUM_CH)) begin
          ch_stage[(int'(word_idx) - 1) * WORD_BITS +: WORD_BITS] <= word_full;
        end
      end else begin
        word_bit <= word_bit + 1'b1;
      end
    end
  end

  // Transfer verdict; word_idx counts completed words, word_bit any trailing partial word.
  assign close      = (state == ST_CLOSE);
  assign partial    = (word_bit != '0);
  assign full_frame = (word_idx == 8'(FRAME_WORDS)) && !partial;
  assign sv_nxt     = close && (word_idx != 8'd0);
  assign fe_nxt     = close && (partial || (word_idx > 8'(FRAME_WORDS)));
  assign dv_nxt     = close && full_frame && crc_ok;

`ifdef ADS131_CRC_EN
  logic [15:0] crc_calc, crc_hold;
  logic        crc_bit_en, ce_q;

  assign crc_bit_en = sample && (word_idx < 8'(FRAME_WORDS - 1));

  crc16_ccitt_serial u_crc (
    .clk      (system_clock),
    .rst      (reset),
    .clear    (start),
    .bit_en   (crc_bit_en),
    .data_bit (miso_bit),
    .crc      (crc_calc)
  );

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      crc_hold <= '0;
      ce_q     <= 1'b0;
    end else begin
      if (word_done && (word_idx == 8'(FRAME_WORDS - 1))) crc_hold <= word_full[WORD_BITS-1 -: 16];
      ce_q <= close && full_frame && !crc_ok;
    end
  end

  assign crc_ok      = (crc_hold == crc_calc);
  assign bus.crc_err = ce_q;
`else
  assign crc_ok      = 1'b1;
  assign bus.crc_err = 1'b0;
`endif

  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      status_word_q <= '0;
      ch_data_q     <= '0;
      sv_q          <= 1'b0;
      dv_q          <= 1'b0;
      fe_q          <= 1'b0;
    end else begin
      sv_q <= sv_nxt;
      dv_q <= dv_nxt;
      fe_q <= fe_nxt;
      if (sv_nxt) status_word_q <= status_hold;
      if (dv_nxt) ch_data_q     <= ch_stage;
    end
  end

  assign bus.status_word  = status_word_q;
  assign bus.status_valid = sv_q;
  assign bus.ch_data      = ch_data_q;
  assign bus.data_valid   = dv_q;
  assign bus.frame_err    = fe_q;
  assign bus.bit_count    = bit_cnt;

endmodule

// File: tb/tb_ads131_frame_receiver.sv
// tb/tb_ads131_frame_receiver.sv - directed and randomized bench for ads131_frame_receiver
`timescale 1ns/1ps
module tb_ads131_frame_receiver;
  localparam int W    = 24;
  localparam int NCH  = 4;
`ifdef ADS131_CRC_EN
  localparam int FW   = NCH + 2;
`else
  localparam int FW   = NCH + 1;
`endif
  localparam int HALF = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  ads131_frame_receiver_if #(.WORD_BITS(W), .NUM_CH(NCH)) bus ();

  ads131_frame_receiver #(.WORD_BITS(W), .NUM_CH(NCH)) dut (
    .system_clock (clk),
    .reset        (rst),
    .bus          (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int sv_cnt = 0, dv_cnt = 0, fe_cnt = 0, ce_cnt = 0, dv_alone = 0, last_pulse_cyc = 0;
  logic [15:0] sv_hist[$];

  always @(negedge clk) begin
    if (bus.status_valid) begin
      sv_cnt++;
      sv_hist.push_back(bus.status_word);
      last_pulse_cyc = cyc;
    end
    if (bus.data_valid) begin
      dv_cnt++;
      if (!bus.status_valid) dv_alone++;
    end
    if (bus.frame_err) begin
      fe_cnt++;
      last_pulse_cyc = cyc;
    end
    if (bus.crc_err) ce_cnt++;
  end

  int n_cmp = 0, n_bad = 0;
  logic [15:0]      exp_status = '0;
  logic [NCH*W-1:0] exp_ch = '0;
  int exp_sv = 0, exp_dv = 0, exp_fe = 0, exp_ce = 0, exp_bc = 0;
  int rise_cyc = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".status_word"}, 128'(bus.status_word), 128'(exp_status));
    check({tag, ".ch_data"},     128'(bus.ch_data),     128'(exp_ch));
    check({tag, ".bit_count"},   128'(bus.bit_count),   128'(exp_bc));
    check({tag, ".status_valid_pulses"}, 128'(sv_cnt), 128'(exp_sv));
    check({tag, ".data_valid_pulses"},   128'(dv_cnt), 128'(exp_dv));
    check({tag, ".frame_err_pulses"},    128'(fe_cnt), 128'(exp_fe));
    check({tag, ".crc_err_pulses"},      128'(ce_cnt), 128'(exp_ce));
  endtask

`ifdef ADS131_CRC_EN
  function automatic logic [15:0] crc_bits(input logic [255:0] v, input int n, input int cnt);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < cnt; i++) begin
      fb = c[15] ^ v[n-1-i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction
`endif

  // Reference: the transfer is n bits, first bit on the wire at v[n-1].
  task automatic model_xfer(input logic [255:0] v, input int n);
    int          words, rem;
    logic [255:0] t;
    logic        good;
    words  = n / W;
    rem    = n % W;
    exp_bc = (n > 255) ? 255 : n;
    if (words >= 1) begin
      t = v >> (n - 16);
      exp_status = t[15:0];
      exp_sv++;
    end
    if (rem != 0 || words > FW) exp_fe++;
    if (words == FW && rem == 0) begin
      good = 1'b1;
`ifdef ADS131_CRC_EN
      t    = v >> (W - 16);
      good = (t[15:0] == crc_bits(v, n, (FW - 1) * W));
      if (!good) exp_ce++;
`endif
      if (good) begin
        for (int k = 0; k < NCH; k++) begin
          t = v >> (n - (k + 2) * W);
          exp_ch[k*W +: W] = t[W-1:0];
        end
        exp_dv++;
      end
    end
  endtask

  task automatic cs_low();
    @(posedge clk);
    #1 bus.spi_cs = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic cs_high(input int gap);
    @(posedge clk);
    #1 bus.spi_cs = 1'b1;
    rise_cyc = cyc;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [255:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bus.spi_sclk = 1'b1;
      bus.spi_miso = v[i];
      repeat (HALF) @(posedge clk);
      #1 bus.spi_sclk = 1'b0;
      repeat (HALF) @(posedge clk);
      #1;
    end
  endtask

  task automatic xfer(input logic [255:0] v, input int n, input int gap);
    cs_low();
    shift_bits(v, n);
    cs_high(gap);
    model_xfer(v, n);
  endtask

  logic [255:0] v, vgood;
  int           n, h0;
  logic [W-1:0] frame_words [5];
`ifdef ADS131_CRC_EN
  logic [15:0]  c;
`endif

  initial begin
    bus.spi_sclk = 1'b0;
    bus.spi_cs   = 1'b1;
    bus.spi_miso = 1'b0;
    frame_words[0] = 24'h220000;
    frame_words[1] = 24'h000001;
    frame_words[2] = 24'h7FFFFF;
    frame_words[3] = 24'h800000;
    frame_words[4] = 24'hFFFFFF;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_all("reset");

    v = 256'hFF0400;
    xfer(v, 24, 25);
    check_all("ready");
    check("ready.status_const", 128'(bus.status_word), 128'(16'hFF04));
    check("ready.latency", 128'(last_pulse_cyc - rise_cyc), 128'd4);

    v = '0;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      v = (v << W) | 256'(frame_words[k]);
      n += W;
    end
`ifdef ADS131_CRC_EN
    c = crc_bits(v, n, n);
    v = (v << W) | 256'({c, 8'h00});
    n += W;
`endif
    vgood = v;
    xfer(v, n, 25);
    check_all("frame");
    check("frame.ch_const", 128'(bus.ch_data), 128'(96'hFFFFFF_800000_7FFFFF_000001));
    check("frame.status_const", 128'(bus.status_word), 128'(16'h2200));

`ifdef ADS131_CRC_EN
    v = vgood ^ (256'(1) << (n - W - 5));
    xfer(v, n, 25);
    check_all("crc_flip");
    check("crc_flip.crc_err_seen", 128'(ce_cnt), 128'd1);
`endif

    v = 256'h1A2B3C;
    xfer(v, 13, 25);
    check_all("short13");
    check("short13.bit_count_const", 128'(bus.bit_count), 128'd13);

    xfer(v, 0, 25);
    check_all("empty");

    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    xfer(v, (FW + 1) * W, 25);
    check_all("overlong");

    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    cs_low();
    shift_bits(v, 30);
    @(posedge clk);
    #1 rst = 1'b1;
    exp_status = '0;
    exp_ch     = '0;
    exp_bc     = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_all("reset_mid");
    shift_bits(v, 5);
    cs_high(25);
    check_all("abandoned");
    v = 256'h065500;
    xfer(v, 24, 25);
    check_all("after_reset");
    check("after_reset.status_const", 128'(bus.status_word), 128'(16'h0655));

    h0 = sv_hist.size();
    v = 256'h065500;
    xfer(v, 24, 2 * 2 * HALF);
    v = 256'h055500;
    xfer(v, 24, 25);
    check_all("b2b");
    check("b2b.pulses", 128'(sv_hist.size() - h0), 128'd2);
    if (sv_hist.size() >= h0 + 2) begin
      check("b2b.first",  128'(sv_hist[h0]),     128'(16'h0655));
      check("b2b.second", 128'(sv_hist[h0 + 1]), 128'(16'h0555));
    end

    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      case ($urandom_range(0, 5))
        0:       n = int'($urandom_range(1, W - 1));
        1:       n = W * int'($urandom_range(1, 3));
        2, 3:    n = FW * W;
        4:       n = int'($urandom_range(W + 1, 200));
        default: n = 0;
      endcase
      xfer(v, n, 25);
      check_all($sformatf("rand%0d", it));
    end

    check("data_valid_without_status", 128'(dv_alone), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
